// File: rtl/game_pkg.sv
// Shared constants, FSM encoding and wrap helpers for the game select controller.
// Optional auto-repeat is enabled by defining GAME_AUTOREPEAT_EN.
package game_pkg;

    localparam int SLOTS         = 10;
    localparam int MAX_DIGIT     = 9;
    localparam int REPEAT_FRAMES = 8;
    localparam int DIGIT_W       = 4;

    localparam logic [3:0] NO_SEL = 4'hF;

    typedef enum logic [1:0] {
        BROWSE = 2'd0,
        EDIT   = 2'd1,
        WRITE  = 2'd2
    } state_t;

    // Increment with wrap at an explicit maximum (not natural 4-bit overflow).
    function automatic logic [3:0] wrap_inc(input logic [3:0] v, input logic [3:0] max);
        return (v == max) ? 4'd0 : v + 4'd1;
    endfunction

    // Decrement with wrap from zero to an explicit maximum.
    function automatic logic [3:0] wrap_dec(input logic [3:0] v, input logic [3:0] max);
        return (v == 4'd0) ? max : v - 4'd1;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Per-button sync register and rising-edge detector.
// With GAME_AUTOREPEAT_EN defined, a held button also emits one synthetic
// event every REPEAT_FRAMES frame strobes while i_rep_en is high.
module btn_edge
    import game_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
`ifdef GAME_AUTOREPEAT_EN
    input  logic i_frame_start,
    input  logic i_rep_en,
`endif
    input  logic i_btn,
    output logic o_event
);

    logic r_cur;
    logic r_prev;
    logic w_edge;

    // Sample the button level once and keep the previous sample for edge detect.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cur  <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_cur  <= i_btn;
            r_prev <= r_cur;
        end
    end

    assign w_edge = r_cur & ~r_prev;

`ifdef GAME_AUTOREPEAT_EN
    localparam int CNT_W = $clog2(REPEAT_FRAMES + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_rep;

    assign w_rep = i_frame_start && i_rep_en && r_cur &&
                   (r_cnt == CNT_W'(REPEAT_FRAMES - 1));

    // Count frames while held; restart on release, on leaving the enabling state, or after a repeat.
    always_ff @(posedge i_clk) begin
        if (i_rst || !r_cur || !i_rep_en) begin
            r_cnt <= '0;
        end else if (i_frame_start) begin
            if (w_rep) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_event = w_edge | w_rep;
`else
    assign o_event = w_edge;
`endif

endmodule

// File: rtl/game_select_ctrl.sv
// Game-logic stage: button events drive cursor moves and digit edits on a
// working copy of the board; display outputs copy the working state only on
// frame_start so the renderer never sees a mid-frame change.
// Optional auto-repeat of up/down in EDIT: define GAME_AUTOREPEAT_EN.
module game_select_ctrl
    import game_pkg::*;
(
    input  logic                       vga_clk,
    input  logic                       vga_rst,
    input  logic                       frame_start,
    input  logic                       btn_left,
    input  logic                       btn_right,
    input  logic                       btn_up,
    input  logic                       btn_down,
    input  logic                       btn_ok,
    input  logic                       btn_cancel,
    input  logic                       clear,
    output logic [SLOTS*DIGIT_W-1:0]   status,
    output logic [DIGIT_W-1:0]         predict,
    output logic                       selecting,
    output logic [3:0]                 cur_select,
    output logic [3:0]                 selected
);

    logic [SLOTS*DIGIT_W-1:0] w_status;
    logic [DIGIT_W-1:0]       w_predict;
    logic [3:0]               w_cur;
    logic [3:0]               w_sel;
    state_t                   w_state;

    logic w_ev_left, w_ev_right, w_ev_up, w_ev_down, w_ev_ok, w_ev_cancel;
    logic w_ud, w_lr;

    btn_edge u_left (
        .i_clk(vga_clk), .i_rst(vga_rst),
`ifdef GAME_AUTOREPEAT_EN
        .i_frame_start(frame_start), .i_rep_en(1'b0),
`endif
        .i_btn(btn_left), .o_event(w_ev_left)
    );

    btn_edge u_right (
        .i_clk(vga_clk), .i_rst(vga_rst),
`ifdef GAME_AUTOREPEAT_EN
        .i_frame_start(frame_start), .i_rep_en(1'b0),
`endif
        .i_btn(btn_right), .o_event(w_ev_right)
    );

    btn_edge u_up (
        .i_clk(vga_clk), .i_rst(vga_rst),
`ifdef GAME_AUTOREPEAT_EN
        .i_frame_start(frame_start), .i_rep_en(w_state == EDIT),
`endif
        .i_btn(btn_up), .o_event(w_ev_up)
    );

    btn_edge u_down (
        .i_clk(vga_clk), .i_rst(vga_rst),
`ifdef GAME_AUTOREPEAT_EN
        .i_frame_start(frame_start), .i_rep_en(w_state == EDIT),
`endif
        .i_btn(btn_down), .o_event(w_ev_down)
    );

    btn_edge u_ok (
        .i_clk(vga_clk), .i_rst(vga_rst),
`ifdef GAME_AUTOREPEAT_EN
        .i_frame_start(frame_start), .i_rep_en(1'b0),
`endif
        .i_btn(btn_ok), .o_event(w_ev_ok)
    );

    btn_edge u_cancel (
        .i_clk(vga_clk), .i_rst(vga_rst),
`ifdef GAME_AUTOREPEAT_EN
        .i_frame_start(frame_start), .i_rep_en(1'b0),
`endif
        .i_btn(btn_cancel), .o_event(w_ev_cancel)
    );

    // Opposing edges in the same cycle cancel out.
    assign w_ud = w_ev_up ^ w_ev_down;
    assign w_lr = w_ev_left ^ w_ev_right;

    // FSM over the working registers plus frame-synchronous commit to the outputs.
    // The commit reads the pre-update working values, so an update landing on a
    // strobe cycle only becomes visible at the following strobe.
    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            w_status   <= '0;
            w_predict  <= '0;
            w_cur      <= '0;
            w_sel      <= NO_SEL;
            w_state    <= BROWSE;
            status     <= '0;
            predict    <= '0;
            selecting  <= 1'b0;
            cur_select <= '0;
            selected   <= NO_SEL;
        end else begin
            if (frame_start) begin
                status     <= w_status;
                predict    <= w_predict;
                selecting  <= (w_state == EDIT);
                cur_select <= w_cur;
                selected   <= w_sel;
            end

            if (clear) begin
                w_status  <= '0;
                w_sel     <= NO_SEL;
                w_predict <= '0;
                w_state   <= BROWSE;
            end else begin
                unique case (w_state)
                    BROWSE: begin
                        if (w_ev_cancel) begin
                            // ignored in BROWSE, but still consumes this cycle
                        end else if (w_ev_ok) begin
                            w_predict <= w_status[w_cur*DIGIT_W +: DIGIT_W];
                            w_state   <= EDIT;
                        end else if (w_ud) begin
                            // ignored in BROWSE
                        end else if (w_lr) begin
                            w_cur <= w_ev_right ? wrap_inc(w_cur, 4'(SLOTS - 1))
                                                : wrap_dec(w_cur, 4'(SLOTS - 1));
                        end
                    end
                    EDIT: begin
                        if (w_ev_cancel) begin
                            w_state <= BROWSE;
                        end else if (w_ev_ok) begin
                            w_state <= WRITE;
                        end else if (w_ud) begin
                            w_predict <= w_ev_up ? wrap_inc(w_predict, 4'(MAX_DIGIT))
                                                 : wrap_dec(w_predict, 4'(MAX_DIGIT));
                        end
                    end
                    WRITE: begin
                        w_status[w_cur*DIGIT_W +: DIGIT_W] <= w_predict;
                        w_sel   <= w_cur;
                        w_state <= BROWSE;
                    end
                    default: w_state <= BROWSE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_select_ctrl.sv
// Directed self-checking bench for game_select_ctrl (default build).
module tb_game_select_ctrl;

    logic        vga_clk = 1'b0;
    logic        vga_rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0;
    logic        btn_down = 1'b0, btn_ok = 1'b0, btn_cancel = 1'b0;
    logic        clear = 1'b0;
    logic [39:0] status;
    logic [3:0]  predict;
    logic        selecting;
    logic [3:0]  cur_select;
    logic [3:0]  selected;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [5:0] B_LEFT   = 6'b000001;
    localparam logic [5:0] B_RIGHT  = 6'b000010;
    localparam logic [5:0] B_UP     = 6'b000100;
    localparam logic [5:0] B_DOWN   = 6'b001000;
    localparam logic [5:0] B_OK     = 6'b010000;
    localparam logic [5:0] B_CANCEL = 6'b100000;

    always #5 vga_clk = ~vga_clk;

    game_select_ctrl dut (
        .vga_clk(vga_clk), .vga_rst(vga_rst), .frame_start(frame_start),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up),
        .btn_down(btn_down), .btn_ok(btn_ok), .btn_cancel(btn_cancel),
        .clear(clear), .status(status), .predict(predict),
        .selecting(selecting), .cur_select(cur_select), .selected(selected)
    );

    task automatic idle(input int n);
        repeat (n) @(negedge vga_clk);
    endtask

    task automatic set_btns(input logic [5:0] m);
        {btn_cancel, btn_ok, btn_down, btn_up, btn_right, btn_left} = m;
    endtask

    // One-cycle press, then enough cycles for sync, process and a WRITE cycle.
    task automatic press(input logic [5:0] m);
        set_btns(m);
        idle(1);
        set_btns(6'b0);
        idle(3);
    endtask

    task automatic strobe();
        frame_start = 1'b1;
        idle(1);
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        vga_rst = 1'b1;
        idle(3);
        vga_rst = 1'b0;
        idle(1);
        strobe();
        n_cmp++; if (status !== 40'h0) begin n_err++; $display("FAIL reset_status: got %h expected %h", status, 40'h0); end
        n_cmp++; if (predict !== 4'd0) begin n_err++; $display("FAIL reset_predict: got %0d expected 0", predict); end
        n_cmp++; if (selecting !== 1'b0) begin n_err++; $display("FAIL reset_selecting: got %b expected 0", selecting); end
        n_cmp++; if (cur_select !== 4'd0) begin n_err++; $display("FAIL reset_cur: got %0d expected 0", cur_select); end
        n_cmp++; if (selected !== 4'hF) begin n_err++; $display("FAIL reset_selected: got %h expected f", selected); end
    endtask

    task automatic test_cursor();
        press(B_LEFT);
        strobe();
        n_cmp++; if (cur_select !== 4'd9) begin n_err++; $display("FAIL cursor_wrap_left: got %0d expected 9", cur_select); end
        press(B_RIGHT);
        strobe();
        n_cmp++; if (cur_select !== 4'd0) begin n_err++; $display("FAIL cursor_wrap_right: got %0d expected 0", cur_select); end
        press(B_RIGHT); press(B_RIGHT); press(B_RIGHT);
        strobe();
        n_cmp++; if (cur_select !== 4'd3) begin n_err++; $display("FAIL cursor_to_3: got %0d expected 3", cur_select); end
        press(B_UP);
        strobe();
        n_cmp++; if (selecting !== 1'b0 || predict !== 4'd0) begin n_err++; $display("FAIL browse_up_ignored: got sel=%b pred=%0d expected sel=0 pred=0", selecting, predict); end
    endtask

    task automatic test_edit();
        press(B_OK);
        for (int i = 0; i < 5; i++) press(B_UP);
        strobe();
        n_cmp++; if (selecting !== 1'b1) begin n_err++; $display("FAIL edit_selecting: got %b expected 1", selecting); end
        n_cmp++; if (predict !== 4'd5) begin n_err++; $display("FAIL edit_predict: got %0d expected 5", predict); end
        n_cmp++; if (cur_select !== 4'd3) begin n_err++; $display("FAIL edit_cur: got %0d expected 3", cur_select); end
        press(B_OK);
        strobe();
        n_cmp++; if (status !== 40'h0000005000) begin n_err++; $display("FAIL write_status: got %h expected %h", status, 40'h0000005000); end
        n_cmp++; if (selected !== 4'd3) begin n_err++; $display("FAIL write_selected: got %h expected 3", selected); end
        n_cmp++; if (selecting !== 1'b0) begin n_err++; $display("FAIL write_selecting: got %b expected 0", selecting); end
    endtask

    task automatic test_wrap_cancel();
        press(B_LEFT); press(B_LEFT); press(B_LEFT);
        press(B_OK);
        press(B_DOWN);
        strobe();
        n_cmp++; if (predict !== 4'd9) begin n_err++; $display("FAIL edit_wrap_down: got %0d expected 9", predict); end
        n_cmp++; if (cur_select !== 4'd0) begin n_err++; $display("FAIL wrap_cur: got %0d expected 0", cur_select); end
        press(B_UP);
        strobe();
        n_cmp++; if (predict !== 4'd0) begin n_err++; $display("FAIL edit_wrap_up: got %0d expected 0", predict); end
        press(B_DOWN);
        press(B_CANCEL);
        strobe();
        n_cmp++; if (status !== 40'h0000005000) begin n_err++; $display("FAIL cancel_status: got %h expected %h", status, 40'h0000005000); end
        n_cmp++; if (selected !== 4'd3) begin n_err++; $display("FAIL cancel_selected: got %h expected 3", selected); end
        n_cmp++; if (selecting !== 1'b0) begin n_err++; $display("FAIL cancel_selecting: got %b expected 0", selecting); end
        n_cmp++; if (predict !== 4'd9) begin n_err++; $display("FAIL cancel_predict_kept: got %0d expected 9", predict); end
    endtask

    task automatic test_tearing();
        press(B_RIGHT);
        idle(1000);
        n_cmp++; if (cur_select !== 4'd0) begin n_err++; $display("FAIL tear_hold: got %0d expected 0", cur_select); end
        strobe();
        n_cmp++; if (cur_select !== 4'd1) begin n_err++; $display("FAIL tear_commit: got %0d expected 1", cur_select); end
        // Strobe lands on the same cycle the cursor moves 1 -> 2.
        btn_right = 1'b1;
        idle(1);
        btn_right = 1'b0;
        frame_start = 1'b1;
        idle(1);
        frame_start = 1'b0;
        n_cmp++; if (cur_select !== 4'd1) begin n_err++; $display("FAIL tear_same_cycle: got %0d expected 1", cur_select); end
        idle(2);
        strobe();
        n_cmp++; if (cur_select !== 4'd2) begin n_err++; $display("FAIL tear_next_strobe: got %0d expected 2", cur_select); end
    endtask

    task automatic test_priority_clear();
        press(B_OK);
        press(B_UP); press(B_UP);
        press(B_UP | B_DOWN);
        strobe();
        n_cmp++; if (predict !== 4'd2) begin n_err++; $display("FAIL updown_cancel: got %0d expected 2", predict); end
        press(B_OK | B_CANCEL);
        strobe();
        n_cmp++; if (selecting !== 1'b0) begin n_err++; $display("FAIL prio_cancel_selecting: got %b expected 0", selecting); end
        n_cmp++; if (status !== 40'h0000005000) begin n_err++; $display("FAIL prio_cancel_status: got %h expected %h", status, 40'h0000005000); end
        n_cmp++; if (selected !== 4'd3) begin n_err++; $display("FAIL prio_cancel_selected: got %h expected 3", selected); end
        press(B_LEFT | B_RIGHT);
        strobe();
        n_cmp++; if (cur_select !== 4'd2) begin n_err++; $display("FAIL leftright_cancel: got %0d expected 2", cur_select); end
        press(B_OK);
        press(B_UP);
        strobe();
        n_cmp++; if (selecting !== 1'b1 || predict !== 4'd1) begin n_err++; $display("FAIL pre_clear_edit: got sel=%b pred=%0d expected sel=1 pred=1", selecting, predict); end
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        idle(1);
        strobe();
        n_cmp++; if (status !== 40'h0) begin n_err++; $display("FAIL clear_status: got %h expected %h", status, 40'h0); end
        n_cmp++; if (selected !== 4'hF) begin n_err++; $display("FAIL clear_selected: got %h expected f", selected); end
        n_cmp++; if (selecting !== 1'b0) begin n_err++; $display("FAIL clear_selecting: got %b expected 0", selecting); end
        n_cmp++; if (predict !== 4'd0) begin n_err++; $display("FAIL clear_predict: got %0d expected 0", predict); end
        n_cmp++; if (cur_select !== 4'd2) begin n_err++; $display("FAIL clear_cur_kept: got %0d expected 2", cur_select); end
    endtask

    task automatic test_reset_mid_edit();
        press(B_OK);
        press(B_UP);
        vga_rst = 1'b1;
        idle(2);
        vga_rst = 1'b0;
        idle(1);
        strobe();
        n_cmp++; if (selecting !== 1'b0) begin n_err++; $display("FAIL rst_edit_selecting: got %b expected 0", selecting); end
        n_cmp++; if (predict !== 4'd0) begin n_err++; $display("FAIL rst_edit_predict: got %0d expected 0", predict); end
        n_cmp++; if (cur_select !== 4'd0) begin n_err++; $display("FAIL rst_edit_cur: got %0d expected 0", cur_select); end
        n_cmp++; if (selected !== 4'hF) begin n_err++; $display("FAIL rst_edit_selected: got %h expected f", selected); end
        // After reset the FSM must be in BROWSE: left moves the cursor.
        press(B_LEFT);
        strobe();
        n_cmp++; if (cur_select !== 4'd9) begin n_err++; $display("FAIL rst_edit_browse: got %0d expected 9", cur_select); end
    endtask

    initial begin
        test_reset();
        test_cursor();
        test_edit();
        test_wrap_cancel();
        test_tearing();
        test_priority_clear();
        test_reset_mid_edit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
